// File: rtl/gs_frame_pkg.sv
// Shared sizes and FSM encoding for the TLC5940 grayscale frame loader.
package gs_frame_pkg;

   localparam int NUM_CHAINS = 4;
   localparam int NUM_CH     = 16;
   localparam int GS_W       = 12;
   localparam int DATA_LSB   = 2;
   localparam int DATA_MSB   = DATA_LSB + NUM_CH * GS_W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      COPY = 2'd2
   } state_t;

endpackage

// File: rtl/gs_gamma.sv
// Combinational gamma curve: squares the low byte of a grayscale value, keeps the top 12 bits.
module gs_gamma
   import gs_frame_pkg::*;
(
   input  logic [GS_W-1:0] din,
   output logic [GS_W-1:0] dout
);

   logic [15:0] sq;
   logic        unused_bits;

   assign sq          = {8'd0, din[7:0]} * {8'd0, din[7:0]};
   assign dout        = sq[15:4];
   assign unused_bits = ^{din[11:8], sq[3:0]};

endmodule

// File: rtl/gs_frame_loader.sv
// Double-buffered grayscale frame store for four TLC5940 chains; shadow swaps to active on xlat.
// Optional GS_GAMMA_EN applies a squaring gamma curve to every write.
module gs_frame_loader
   import gs_frame_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [1:0]                 wr_chain,
   input  logic [3:0]                 wr_chan,
   input  logic [GS_W-1:0]            wr_data,
   input  logic                       commit,
   input  logic                       clr,
   input  logic                       xlat,
   output logic [DATA_MSB:DATA_LSB]   data_register0,
   output logic [DATA_MSB:DATA_LSB]   data_register1,
   output logic [DATA_MSB:DATA_LSB]   data_register2,
   output logic [DATA_MSB:DATA_LSB]   data_register3,
   output logic                       commit_done,
   output logic                       busy,
   output logic [7:0]                 frame_cnt,
   output logic [1:0]                 state_dbg
);

   // Handshake: a write is taken on a rising clk edge where wr_valid and wr_ready are both high;
   // wr_ready never waits on wr_valid, and a refused write is simply dropped.

   state_t                    state_q, state_d;
   logic                      xlat_q;
   logic                      xlat_rise;
   logic                      wr_fire;
   logic                      swap;
   logic [GS_W-1:0]           wr_value;
   logic [GS_W-1:0]           shadow [NUM_CHAINS][NUM_CH];
   logic [DATA_MSB:DATA_LSB]  active [NUM_CHAINS];

`ifdef GS_GAMMA_EN
   gs_gamma u_gamma (
      .din  (wr_data),
      .dout (wr_value)
   );
`else
   assign wr_value = wr_data;
`endif

   assign xlat_rise   = xlat & ~xlat_q;
   assign wr_ready    = (state_q == IDLE) & ~clr;
   assign wr_fire     = wr_valid & wr_ready;
   assign busy        = (state_q != IDLE);
   assign commit_done = (state_q == COPY);
   assign state_dbg   = state_q;
   assign swap        = (state_q == PEND) & (state_d == COPY);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit && !clr) state_d = PEND;
         PEND:    if (xlat_rise) state_d = COPY;
         COPY:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         xlat_q    <= 1'b0;
         frame_cnt <= 8'd0;
      end else begin
         state_q <= state_d;
         xlat_q  <= xlat;
         if (swap) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // clr only acts in IDLE so a pending frame can never be zeroed under the swap.
   always_ff @(posedge clk) begin
      if (rst || (clr && state_q == IDLE)) begin
         for (int c = 0; c < NUM_CHAINS; c++)
            for (int k = 0; k < NUM_CH; k++)
               shadow[c][k] <= '0;
      end else if (wr_fire) begin
         shadow[wr_chain][wr_chan] <= wr_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CHAINS; c++)
            active[c] <= '0;
      end else if (swap) begin
         for (int c = 0; c < NUM_CHAINS; c++)
            for (int k = 0; k < NUM_CH; k++)
               active[c][DATA_LSB + k*GS_W +: GS_W] <= shadow[c][k];
      end
   end

   assign data_register0 = active[0];
   assign data_register1 = active[1];
   assign data_register2 = active[2];
   assign data_register3 = active[3];

endmodule

// File: doc/gs_frame_loader.md
GS_FRAME_LOADER -- requirements
Module: gs_frame_loader

Interface
REQ-001 SHALL have one clock and a synchronous active-high reset: clk input 1 (rising-edge clock), rst input 1 (synchronous, active-high).
REQ-002 SHALL have wr_valid input 1: host grayscale write request.
REQ-003 SHALL have wr_ready output 1: write accepted when wr_valid and wr_ready are both high at a rising clk edge.
REQ-004 SHALL have wr_chain input 2: target TLC5940 chain, 0..3.
REQ-005 SHALL have wr_chan input 4: target channel (OUTn), 0..15.
REQ-006 SHALL have wr_data input 12: grayscale value.
REQ-007 SHALL have commit input 1: single-cycle pulse requesting a shadow-to-active frame swap.
REQ-008 SHALL have clr input 1: single-cycle pulse zeroing the shadow bank.
REQ-009 SHALL have xlat input 1: latch strobe from the downstream TLC5940 serial driver, used as the frame boundary.
REQ-010 SHALL have data_register0..3 outputs [193:2] each: active grayscale frames feeding the downstream serial driver.
REQ-011 SHALL have commit_done output 1: one-cycle pulse when the active frame is updated.
REQ-012 SHALL have busy output 1: high in PEND or COPY.
REQ-013 SHALL have frame_cnt output 8: count of completed commits.

Function
REQ-014 SHALL hold a 4x16x12 shadow bank; each accepted write updates entry [wr_chain][wr_chan] at that clock edge.
REQ-015 SHALL map channel k of chain c to data_register<c>[12k+13:12k+2], so channel 15 occupies [193:182] and channel 0 occupies [13:2].
REQ-016 SHALL implement states IDLE, PEND and COPY.
REQ-017 SHALL drive wr_ready = (state==IDLE) & ~clr.
REQ-018 SHALL, in IDLE on commit, move to PEND; a write accepted in the same cycle SHALL be included in the committed frame.
REQ-019 SHALL detect an xlat rising edge as xlat=1 with registered xlat_q=0; in PEND on that edge it SHALL move to COPY.
REQ-020 SHALL, on the edge entering COPY, load all four data_registers from the shadow bank at once; commit_done SHALL be high for exactly the COPY cycle; COPY SHALL return to IDLE unconditionally.
REQ-021 SHALL increment frame_cnt on entering COPY, wrapping 255->0.
REQ-022 SHALL ignore commit while in PEND or COPY (no queueing).
REQ-023 SHALL, on clr in IDLE, zero all 64 shadow entries at that edge; clr SHALL win over a simultaneous write or commit, and clr outside IDLE SHALL be ignored.
REQ-024 SHALL ignore an xlat edge in IDLE; active data SHALL change only via COPY.
REQ-025 SHALL ignore wr_valid while wr_ready is low (no stall buffering).

Reset
REQ-026 SHALL, on rst, set state to IDLE, set data_register0..3, shadow bank, frame_cnt, xlat_q, commit_done and busy to 0, and set wr_ready to 1 from the next cycle.
REQ-027 SHALL, on rst during PEND or COPY, abort the swap with no commit_done and no frame_cnt increment.

Configuration
REQ-028 SHALL, with GS_GAMMA_EN defined, store (wr_data[7:0]*wr_data[7:0])>>4 (16-bit product, 12-bit result) and ignore wr_data[11:8], adding no cycle of latency.
REQ-029 SHALL, without GS_GAMMA_EN, store wr_data unchanged.

Structure
REQ-030 SHALL place NUM_CHAINS=4, NUM_CH=16, GS_W=12, DATA_LSB=2 and the state encoding in shared package gs_frame_pkg.
REQ-031 SHALL implement gamma as combinational sub-module gs_gamma, instantiated only under GS_GAMMA_EN.

Verification
REQ-032 SHALL cover: write chain2/ch15=0xABC, commit, xlat pulse -> data_register2[193:182]=0xABC, commit_done 1 cycle, frame_cnt=1.
REQ-033 SHALL cover: write chain0/ch0=0x123, commit, no xlat for 100 cycles -> data_register0 stays 0, busy=1, wr_ready=0.
REQ-034 SHALL cover: commit and write chain1/ch3=0x7FF in the same cycle, then xlat -> data_register1[49:38]=0x7FF.
REQ-035 SHALL cover: all 64 entries =0xFFF committed, then clr, commit, xlat -> all data_registers =0.
REQ-036 SHALL cover: 256 commit/xlat cycles -> frame_cnt wraps to 0; rst asserted in PEND -> no commit_done and all outputs 0.
REQ-037 SHALL cover, with GS_GAMMA_EN: write 0xFF -> stored 0xFE0; write 0x10 -> stored 0x010.
